fetch_unit_cpu: RTL and testbench
=================================

# fetch_unit_cpu

Instruction fetch stage directly upstream of `control_path_cpu`. It owns the program counter and fetches one instruction per cycle-pair from instruction memory over a req/ack handshake. It presents the decoded fields (opcode, funct, imm, target) to the control path. It then applies the control path's `is_load_PC` / `control_mux_for_PC` decision to compute the next PC.

## Interface
Parameters:
- `WIDTH`, 32: data/address width; only 32 is supported.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `TIMEOUT`, 15: maximum number of wait cycles without ack. Used only with `FETCH_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request; high only in S_WAIT.
- `imem_addr`  out  32  fetch address; always equals `pc`.
- `imem_ack`  in  1  memory has data on `imem_rdata` this cycle.
- `imem_rdata`  in  32  instruction word; sampled only when `imem_req && imem_ack`.
- `is_load_PC`  in  1  from control path: the instruction is legal, so advance the PC.
- `control_mux_for_PC`  in  2  from control path: next-PC select.
- `instr`  out  32  latched instruction.
- `opcode`  out  6  `instr[31:26]`.
- `funct`  out  6  `instr[5:0]`.
- `imm`  out  16  `instr[15:0]`.
- `target`  out  26  `instr[25:0]`.
- `instr_valid`  out  1  high while in S_EXEC.
- `pc`  out  32  address of the current instruction.
- `fetch_err`  out  1  sticky fetch timeout flag.

## Operation
- States: S_IDLE, S_WAIT, S_EXEC, S_HALT.
- Reset (`rst`=0), effective immediately:
  - state ← S_IDLE, `pc` ← RESET_PC, `instr` ← 0, `fetch_err` ← 0.
  - Outputs: `imem_req`=0, `instr_valid`=0.
- S_IDLE → S_WAIT unconditionally (one cycle after reset release).
- S_WAIT:
  - `imem_req`=1, with `imem_addr`=`pc` held stable.
  - On `imem_ack`=1: `instr` ← `imem_rdata`, then go to S_EXEC.
  - Otherwise stay in S_WAIT.
- S_EXEC:
  - `instr_valid`=1; the control path evaluates combinationally within this cycle.
  - At the clock edge, if `is_load_PC`=1: `pc` ← next_pc, then go to S_WAIT.
  - At the clock edge, if `is_load_PC`=0 (unknown opcode): `pc` holds, then go to S_HALT.
- S_HALT: terminal. No requests are issued; `instr_valid`=0. Only reset exits this state.
- next_pc, with pc4 = pc+4 (all arithmetic mod 2^32):
  - 00: pc4
  - 01: pc4 + (sign_extend(imm) << 2)
  - 10: {pc4[31:28], target, 2'b00}
  - 11: pc4 (reserved)
- Wrap-around: pc=32'hFFFF_FFFC with select 00 gives next_pc = 0. No error is raised.
- `imem_ack` is ignored in every state except S_WAIT.
- `is_load_PC` and `control_mux_for_PC` are ignored in every state except S_EXEC.

## Timing
- `instr` is registered. All field outputs are wires from `instr`.
- `imem_req` and `instr_valid` decode from the registered state and are glitch-free.
- Latency:
  - Ack in the first S_WAIT cycle: `instr_valid` is high on the next cycle.
  - Back-to-back with ack in the same cycle as req: one instruction every 2 cycles.
- Each extra cycle of ack delay adds exactly one cycle.
- `pc` changes only on the edge that leaves S_EXEC, so it is stable throughout S_WAIT and S_EXEC.
- Reset asserted mid-S_WAIT drops `imem_req` asynchronously. An ack arriving in the cycle after release is ignored (state is S_IDLE).

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A wait counter clears on S_WAIT entry and increments on each S_WAIT cycle with `imem_ack`=0.
  - When it reaches TIMEOUT: `fetch_err` ← 1 (sticky until reset), state ← S_HALT, `imem_req` drops.
  - An ack in the same cycle the counter reaches TIMEOUT wins: the instruction is captured and no error is flagged.
- Not defined: no counter. `fetch_err` is tied to 0 and S_WAIT waits indefinitely.

## Test plan
- Reset with RESET_PC=0, ack returned in the same cycle as req, then `addi` (opcode 6'b001000) with select 00 → `imem_addr` sequence 0, 4, 8; `instr_valid` pulses every 2nd cycle.
- `beq` at pc=32'h10 with imm=16'hFFFE and select 01 → next `imem_addr`=32'h0C. With imm=16'h0003 → 32'h20.
- `j` at pc=32'h8000_0010 with target=26'h000_0040 and select 10 → next `imem_addr`=32'h8000_0100.
- Ack delayed 5 cycles → `imem_req` high for 6 cycles with `imem_addr` constant. `instr` equals `imem_rdata` from the ack cycle; rdata driven before the ack does not change `instr`.
- Opcode 6'b111111 with `is_load_PC`=0 → state S_HALT, `pc` unchanged, `imem_req` stays 0 for 20+ cycles. Pulsing `rst` low → fetch restarts at RESET_PC.
- `FETCH_TIMEOUT_EN` with TIMEOUT=15 and ack withheld → `fetch_err`=1 after 15 wait cycles, `imem_req`=0. Ack on exactly the 15th cycle → no error, instruction captured.

Source files
------------

// File: rtl/fetch_unit_cpu.sv
// Instruction fetch stage: owns the PC and fetches over a req/ack handshake.
// Optional feature macro FETCH_TIMEOUT_EN adds a bounded wait with a sticky fetch_err.
module fetch_unit_cpu #(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             is_load_PC,
  input  logic [1:0]       control_mux_for_PC,
  output logic [WIDTH-1:0] instr,
  output logic [5:0]       opcode,
  output logic [5:0]       funct,
  output logic [15:0]      imm,
  output logic [25:0]      target,
  output logic             instr_valid,
  output logic [WIDTH-1:0] pc,
  output logic             fetch_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_HALT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] w_pc4;
  logic [WIDTH-1:0] w_br_off;
  logic [WIDTH-1:0] w_next_pc;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_wait_cnt;
  logic          r_err;
`endif

  always_comb begin
    w_pc4    = r_pc + 32'd4;
    w_br_off = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    case (control_mux_for_PC)
      2'b01:   w_next_pc = w_pc4 + w_br_off;
      2'b10:   w_next_pc = {w_pc4[31:28], r_instr[25:0], 2'b00};
      default: w_next_pc = w_pc4;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
`ifdef FETCH_TIMEOUT_EN
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_WAIT;
`ifdef FETCH_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          // A late ack on the final allowed cycle still wins over the timeout.
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_state <= S_EXEC;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (r_wait_cnt == CW'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end
        S_EXEC: begin
          if (is_load_PC) begin
            r_pc    <= w_next_pc;
            r_state <= S_WAIT;
`ifdef FETCH_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
          end else begin
            r_state <= S_HALT;
          end
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  assign imem_req    = (r_state == S_WAIT);
  assign instr_valid = (r_state == S_EXEC);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign opcode      = r_instr[31:26];
  assign funct       = r_instr[5:0];
  assign imm         = r_instr[15:0];
  assign target      = r_instr[25:0];

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = r_err;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit_cpu.sv
// Bench for fetch_unit_cpu: directed vector table, random fetch stream against a PC model,
// halt/reset corners, and the wait bound (timeout build or indefinite wait).
module tb_fetch_unit_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        is_load_PC = 1'b0;
  logic [1:0]  control_mux_for_PC = 2'b00;
  logic        imem_req, instr_valid, fetch_err;
  logic [31:0] imem_addr, instr, pc;
  logic [5:0]  opcode, funct;
  logic [15:0] imm;
  logic [25:0] target;

  // Second instance at a high reset PC, free-running on a jump instruction.
  logic        ack2 = 1'b1;
  logic [31:0] rdata2 = 32'h0800_0040;
  logic        load2 = 1'b1;
  logic [1:0]  sel2 = 2'b10;
  logic        req2, valid2, err2;
  logic [31:0] addr2, instr2, pc2;
  logic [5:0]  opcode2, funct2;
  logic [15:0] imm2;
  logic [25:0] target2;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_unit_cpu #(.WIDTH(32), .RESET_PC(32'h0000_0000), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .is_load_PC(is_load_PC),
    .control_mux_for_PC(control_mux_for_PC), .instr(instr), .opcode(opcode),
    .funct(funct), .imm(imm), .target(target), .instr_valid(instr_valid),
    .pc(pc), .fetch_err(fetch_err)
  );

  fetch_unit_cpu #(.WIDTH(32), .RESET_PC(32'h8000_0010), .TIMEOUT(15)) dut2 (
    .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2), .is_load_PC(load2),
    .control_mux_for_PC(sel2), .instr(instr2), .opcode(opcode2),
    .funct(funct2), .imm(imm2), .target(target2), .instr_valid(valid2),
    .pc(pc2), .fetch_err(err2)
  );

  typedef struct {
    logic [31:0] rd;
    logic [1:0]  sel;
    int          dly;
    logic [31:0] exp_next;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural next-PC rule computed with plain signed arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ins,
                                             input logic [1:0] sel);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    off = int'($signed(ins[15:0])) * 4;
    case (sel)
      2'd1:    return seq + 32'(off);
      2'd2:    return (seq & 32'hF000_0000) | ({6'd0, ins[25:0]} * 32'd4);
      default: return seq;
    endcase
  endfunction

  // Called on a falling edge; returns on the falling edge after the EXEC cycle.
  task automatic do_fetch(input logic [31:0] rd, input logic [1:0] sel, input logic load,
                          input int dly, input logic [31:0] exp_pc);
    int          n;
    logic [31:0] prev;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    prev = instr;
    for (int k = 0; k < dly; k++) begin
      imem_ack           = 1'b0;
      imem_rdata         = $urandom;
      is_load_PC         = 1'($urandom);
      control_mux_for_PC = 2'($urandom);
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, exp_pc);
      chk("wait_instr_hold", instr, prev);
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
    end
    chk("ack_req", {31'd0, imem_req}, 32'd1);
    chk("ack_addr", imem_addr, exp_pc);
    imem_ack   = 1'b1;
    imem_rdata = rd;
    @(negedge clk);
    imem_ack   = 1'($urandom);
    imem_rdata = $urandom;
    chk("exec_valid", {31'd0, instr_valid}, 32'd1);
    chk("exec_req", {31'd0, imem_req}, 32'd0);
    chk("exec_instr", instr, rd);
    chk("exec_opcode", {26'd0, opcode}, {26'd0, rd[31:26]});
    chk("exec_funct", {26'd0, funct}, {26'd0, rd[5:0]});
    chk("exec_imm", {16'd0, imm}, {16'd0, rd[15:0]});
    chk("exec_target", {6'd0, target}, {6'd0, rd[25:0]});
    chk("exec_pc", pc, exp_pc);
    chk("exec_err", {31'd0, fetch_err}, 32'd0);
    is_load_PC         = load;
    control_mux_for_PC = sel;
    @(negedge clk);
    imem_ack           = 1'b0;
    is_load_PC         = 1'($urandom);
    control_mux_for_PC = 2'($urandom);
    chk("post_valid", {31'd0, instr_valid}, 32'd0);
    chk("post_req", {31'd0, imem_req}, {31'd0, load});
    $display("fetch pc=%h instr=%h sel=%0d load=%0d dly=%0d", exp_pc, rd, sel, load, dly);
  endtask

  initial begin
    vec_t        vecs[12];
    logic [31:0] model_pc;
    logic [31:0] rd;
    logic [1:0]  sel;
    int          n;

    vecs[0]  = '{32'h2000_0001, 2'b00, 0, 32'h0000_0004};
    vecs[1]  = '{32'h2000_0001, 2'b00, 0, 32'h0000_0008};
    vecs[2]  = '{32'h2000_0001, 2'b00, 1, 32'h0000_000C};
    vecs[3]  = '{32'h2000_0001, 2'b00, 0, 32'h0000_0010};
    vecs[4]  = '{32'h1000_FFFE, 2'b01, 0, 32'h0000_000C};
    vecs[5]  = '{32'h2000_0001, 2'b00, 0, 32'h0000_0010};
    vecs[6]  = '{32'h1000_0003, 2'b01, 0, 32'h0000_0020};
    vecs[7]  = '{32'h0800_0040, 2'b10, 0, 32'h0000_0100};
    vecs[8]  = '{32'h2000_0001, 2'b11, 2, 32'h0000_0104};
    vecs[9]  = '{32'h1000_FFBD, 2'b01, 0, 32'hFFFF_FFFC};
    vecs[10] = '{32'h2000_0001, 2'b00, 5, 32'h0000_0000};
    vecs[11] = '{32'h0BFF_FFFF, 2'b10, 0, 32'h0FFF_FFFC};

    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_pc2", pc2, 32'h8000_0010);
    rst = 1'b1;
    #1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    chk("first_wait_req", {31'd0, imem_req}, 32'd1);
    chk("dut2_addr0", addr2, 32'h8000_0010);
    @(negedge clk);
    chk("dut2_valid", {31'd0, valid2}, 32'd1);
    chk("dut2_target", {6'd0, target2}, 32'h0000_0040);
    @(negedge clk);
    chk("dut2_jump_addr", addr2, 32'h8000_0100);

    model_pc = 32'h0;
    for (int i = 0; i < 12; i++) begin
      do_fetch(vecs[i].rd, vecs[i].sel, 1'b1, vecs[i].dly, model_pc);
      model_pc = vecs[i].exp_next;
    end

    for (int i = 0; i < 30; i++) begin
      rd  = $urandom;
      sel = 2'($urandom_range(0, 3));
      do_fetch(rd, sel, 1'b1, $urandom_range(0, 3), model_pc);
      model_pc = model_next(model_pc, rd, sel);
    end

    do_fetch(32'hFC00_1234, 2'b01, 1'b0, 1, model_pc);
    for (int i = 0; i < 25; i++) begin
      imem_ack   = 1'($urandom);
      is_load_PC = 1'b1;
      @(negedge clk);
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_pc", pc, model_pc);
    end
    imem_ack = 1'b0;

    #3 rst = 1'b0;
    #1;
    chk("rerst_pc", pc, 32'h0);
    chk("rerst_instr", instr, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'h0);
    #2 rst = 1'b0;
    #1;
    chk("async_req_drop", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("ack_in_idle_req", {31'd0, imem_req}, 32'd1);
    chk("ack_in_idle_instr", instr, 32'h0);
    chk("ack_in_idle_valid", {31'd0, instr_valid}, 32'd0);

    n = 0;
    while (imem_req && n < 40) begin
      n++;
      @(negedge clk);
    end
`ifdef FETCH_TIMEOUT_EN
    chk("timeout_cycles", 32'(n), 32'd15);
    chk("timeout_err", {31'd0, fetch_err}, 32'd1);
    chk("timeout_req", {31'd0, imem_req}, 32'd0);
    repeat (3) @(negedge clk);
    chk("timeout_sticky", {31'd0, fetch_err}, 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("timeout_rst_err", {31'd0, fetch_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_fetch(32'h2000_0005, 2'b00, 1'b1, 14, 32'h0);
    chk("late_ack_no_err", {31'd0, fetch_err}, 32'd0);
`else
    chk("wait_forever_cycles", 32'(n), 32'd40);
    chk("wait_forever_req", {31'd0, imem_req}, 32'd1);
    chk("wait_forever_err", {31'd0, fetch_err}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
